seconds_to_hms_seq: RTL

- Sequential, parametrised converter from an elapsed-seconds count to hour/minute/second fields.
- Replaces the earlier init-time-only conversion with a clocked start/valid handshake and configurable input width.
- Uses bit-serial restoring long division, so no hardware divider is inferred.
- Sits between the seconds counter/timer core and the display/BCD formatting stage.

---
 rtl/seconds_to_hms_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/seconds_to_hms_seq.sv
// Sequential seconds -> hour/minute/second converter using bit-serial restoring division.
// Optional HMS_WRAP_24H_EN macro folds the hour quotient into 0..23 and flags day rollover.
module seconds_to_hms_seq #(
  parameter int unsigned SEC_W  = 17,
  parameter int unsigned HOUR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEC_W-1:0]  sec_in,
  output logic              busy,
  output logic              valid,
  output logic [HOUR_W-1:0] hour,
  output logic [5:0]        minute,
  output logic [5:0]        second,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(SEC_W);

`ifdef HMS_WRAP_24H_EN
  typedef enum logic [2:0] {S_IDLE, S_DIV_H, S_DIV_M, S_WRAP, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_DIV_H, S_DIV_M, S_DONE} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEC_W-1:0]   hq_q, hq_d;      // dividend shifts out, hour quotient shifts in
  logic [11:0]        hrem_q, hrem_d;
  logic [11:0]        mq_q, mq_d;      // same trick for the minute stage
  logic [5:0]         mrem_q, mrem_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [HOUR_W-1:0]  hour_q, hour_d;
  logic [5:0]         minute_q, minute_d;
  logic [5:0]         second_q, second_d;
  logic               overflow_q, overflow_d;
`ifdef HMS_WRAP_24H_EN
  logic               day_q, day_d;
  logic [SEC_W-1:0]   hq_wrap;
`endif

  logic [12:0] hrem_sh;
  logic        hge;
  logic [11:0] hrem_nx;
  logic [6:0]  mrem_sh;
  logic        mge;
  logic [5:0]  mrem_nx;
  logic [11:0] mq_nx;

  always_comb begin
    // Remainders stay below the divisor, so the low-bit subtraction is exact.
    hrem_sh = {hrem_q, hq_q[SEC_W-1]};
    hge     = (hrem_sh >= 13'd3600);
    hrem_nx = hge ? (hrem_sh[11:0] - 12'd3600) : hrem_sh[11:0];
    mrem_sh = {mrem_q, mq_q[11]};
    mge     = (mrem_sh >= 7'd60);
    mrem_nx = mge ? (mrem_sh[5:0] - 6'd60) : mrem_sh[5:0];
    mq_nx   = {mq_q[10:0], mge};
`ifdef HMS_WRAP_24H_EN
    hq_wrap = (hq_q >= SEC_W'(24)) ? (hq_q - SEC_W'(24)) : hq_q;
    day_d   = day_q;
`endif

    state_d    = state_q;
    cnt_d      = cnt_q;
    hq_d       = hq_q;
    hrem_d     = hrem_q;
    mq_d       = mq_q;
    mrem_d     = mrem_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    hour_d     = hour_q;
    minute_d   = minute_q;
    second_d   = second_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          hq_d    = sec_in;
          hrem_d  = '0;
          cnt_d   = CNT_W'(SEC_W - 1);
          busy_d  = 1'b1;
          state_d = S_DIV_H;
        end
      end
      S_DIV_H: begin
        hq_d   = {hq_q[SEC_W-2:0], hge};
        hrem_d = hrem_nx;
        if (cnt_q == '0) begin
          mq_d    = hrem_nx;
          mrem_d  = '0;
          cnt_d   = CNT_W'(11);
          state_d = S_DIV_M;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV_M: begin
        mq_d   = mq_nx;
        mrem_d = mrem_nx;
        if (cnt_q == '0) begin
`ifdef HMS_WRAP_24H_EN
          day_d   = (hq_q >= SEC_W'(24));
          state_d = S_WRAP;
`else
          hour_d     = HOUR_W'(hq_q);
          overflow_d = ((hq_q >> HOUR_W) != '0);
          minute_d   = mq_nx[5:0];
          second_d   = mrem_nx;
          valid_d    = 1'b1;
          state_d    = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef HMS_WRAP_24H_EN
      S_WRAP: begin
        // One subtraction per cycle; finish as soon as the folded value is below 24.
        hq_d = hq_wrap;
        if (hq_wrap < SEC_W'(24)) begin
          hour_d     = HOUR_W'(hq_wrap);
          overflow_d = day_q;
          minute_d   = mq_q[5:0];
          second_d   = mrem_q;
          valid_d    = 1'b1;
          state_d    = S_DONE;
        end
      end
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hq_q       <= '0;
      hrem_q     <= '0;
      mq_q       <= '0;
      mrem_q     <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      hour_q     <= '0;
      minute_q   <= '0;
      second_q   <= '0;
      overflow_q <= 1'b0;
`ifdef HMS_WRAP_24H_EN
      day_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hq_q       <= hq_d;
      hrem_q     <= hrem_d;
      mq_q       <= mq_d;
      mrem_q     <= mrem_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      hour_q     <= hour_d;
      minute_q   <= minute_d;
      second_q   <= second_d;
      overflow_q <= overflow_d;
`ifdef HMS_WRAP_24H_EN
      day_q      <= day_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign hour     = hour_q;
  assign minute   = minute_q;
  assign second   = second_q;
  assign overflow = overflow_q;

endmodule
